// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FSM controller sequencing the multi-cycle MIPS-subset datapath
module multi_cycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ir,
  input  logic                rs_eq_rt,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_wen,
  output logic                pc_wen,
  output logic [1:0]          pc_sel,
  output logic [11:0]         alu_control,
  output logic                alu_src1_sa,
  output logic                alu_src2_imm,
  output logic                dm_req,
  output logic [3:0]          dm_wen,
  output logic                mdr_wen,
  output logic                rf_wen,
  output logic                rf_waddr_sel,
  output logic                rf_wdata_sel,
  output logic                inst_retired,
  output logic [RETIRE_W-1:0] retired_cnt,
  output logic [2:0]          state
);
  localparam logic [2:0] FETCH = 3'd1, DECODE = 3'd2, EXE = 3'd3, MEM = 3'd4, WB = 3'd5;
  logic [2:0] next_state;
  logic [5:0] op, funct;
  logic [4:0] rs, sa;
  logic r_ok, sh_ok;
  logic i_addu, i_subu, i_slt, i_and, i_nor, i_or, i_xor, i_sll, i_srl;
  logic i_addiu, i_beq, i_bne, i_lw, i_sw, i_lui, i_j;
  logic is_r, is_sh, legal, ctl, alu_on;
  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign sa      = ir[10:6];
  assign funct   = ir[5:0];
  assign r_ok    = op == 6'd0 && sa == 5'd0;
  assign sh_ok   = op == 6'd0 && rs == 5'd0;
  assign i_addu  = r_ok && funct == 6'b100001;
  assign i_subu  = r_ok && funct == 6'b100011;
  assign i_slt   = r_ok && funct == 6'b101010;
  assign i_and   = r_ok && funct == 6'b100100;
  assign i_nor   = r_ok && funct == 6'b100111;
  assign i_or    = r_ok && funct == 6'b100101;
  assign i_xor   = r_ok && funct == 6'b100110;
  assign i_sll   = sh_ok && funct == 6'b000000;
  assign i_srl   = sh_ok && funct == 6'b000010;
  assign i_addiu = op == 6'b001001;
  assign i_beq   = op == 6'b000100;
  assign i_bne   = op == 6'b000101;
  assign i_lw    = op == 6'b100011;
  assign i_sw    = op == 6'b101011;
  assign i_lui   = op == 6'b001111;
  assign i_j     = op == 6'b000010;
  assign is_r    = i_addu | i_subu | i_slt | i_and | i_nor | i_or | i_xor;
  assign is_sh   = i_sll | i_srl;
  assign legal   = is_r | is_sh | i_addiu | i_beq | i_bne | i_lw | i_sw | i_lui | i_j;
  assign ctl     = i_j | i_beq | i_bne | !legal;
  assign alu_on  = state == DECODE || state == EXE || state == MEM || state == WB;
  always_ff @(posedge clk) begin
    state       <= reset ? FETCH : next_state;
    retired_cnt <= reset ? '0 : retired_cnt + RETIRE_W'(inst_retired);
  end
  always_comb begin
    case (state)
      FETCH:   next_state = imem_ready ? DECODE : FETCH;
      DECODE:  next_state = ctl ? FETCH : EXE;
      EXE:     next_state = (i_lw || i_sw) ? MEM : WB;
      MEM:     next_state = dmem_ready ? (i_lw ? WB : FETCH) : MEM;
      WB:      next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end
  always_comb begin
    imem_req     = 1'b0;
    ir_wen       = 1'b0;
    pc_wen       = 1'b0;
    pc_sel       = 2'b00;
    dm_req       = 1'b0;
    dm_wen       = 4'h0;
    mdr_wen      = 1'b0;
    rf_wen       = 1'b0;
    rf_waddr_sel = 1'b0;
    rf_wdata_sel = 1'b0;
    inst_retired = 1'b0;
    alu_control  = alu_on ? {i_addu | i_addiu | i_lw | i_sw, i_subu, i_slt, 1'b0, i_and, i_nor,
                             i_or, i_xor, i_sll, i_srl, 1'b0, i_lui} : 12'h000;
    alu_src1_sa  = alu_on && is_sh;
    alu_src2_imm = alu_on && (i_addiu | i_lui | i_lw | i_sw);
    if (!reset)
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_wen   = imem_ready;
        end
        DECODE: begin
          pc_wen       = ctl;
          inst_retired = ctl;
          pc_sel       = i_j ? 2'b10 : ((i_beq && rs_eq_rt) || (i_bne && !rs_eq_rt)) ? 2'b01 : 2'b00;
        end
        MEM: begin
          dm_req       = 1'b1;
          dm_wen       = i_sw ? 4'hF : 4'h0;
          pc_wen       = i_sw && dmem_ready;
          inst_retired = i_sw && dmem_ready;
          mdr_wen      = i_lw && dmem_ready;
        end
        WB: begin
          rf_wen       = 1'b1;
          rf_waddr_sel = is_r | is_sh;
          rf_wdata_sel = i_lw;
          pc_wen       = 1'b1;
          inst_retired = 1'b1;
        end
        default: ;
      endcase
  end
endmodule
